// File: rtl/mc_ring_op.sv
// ---------------------------------------------------------------------------
// mc_ring_op
// Multi-cycle operator for the datapath operator pool. A start loads the two
// operands into a DEPTH-entry rotating register ring. The ring then rotates
// for LATENCY cycles. On the last rotation, ring entries 0 and 1 are combined
// under the mode that was latched at start.
//
// Optional build macro: MC_RING_SATURATE_EN
//    When defined, add and sub operate on signed two's complement values and
//    clamp to the signed range instead of wrapping.
//
// Ports:
//    CLK_I     clock, every state update happens on its rising edge
//    RST_I     asynchronous active-high reset
//    EN_I      global enable; while low, every register holds
//    START_I   operation request, honoured only when READY_O=1 and EN_I=1
//    MODE_I    00 add, 01 sub (r0-r1), 10 xor, 11 pass r0; latched on start
//    OP_A_I    operand A
//    OP_B_I    operand B
//    READY_O   high in IDLE or DONE (new start may be accepted)
//    BUSY_O    high while the ring is rotating (RUN)
//    VALID_O   high while a finished result is presented (DONE)
//    RESULT_O  registered result; holds until the next result is written
// ---------------------------------------------------------------------------
module mc_ring_op #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 3,
   parameter int LATENCY    = 3
) (
   input  logic                  CLK_I,
   input  logic                  RST_I,
   input  logic                  EN_I,
   input  logic                  START_I,
   input  logic [1:0]            MODE_I,
   input  logic [DATA_WIDTH-1:0] OP_A_I,
   input  logic [DATA_WIDTH-1:0] OP_B_I,
   output logic                  READY_O,
   output logic                  BUSY_O,
   output logic                  VALID_O,
   output logic [DATA_WIDTH-1:0] RESULT_O
);

   localparam int CNT_W = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [DATA_WIDTH-1:0] ring_q [DEPTH];
   logic [CNT_W-1:0]      cnt_q;
   logic [1:0]            mode_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic [DATA_WIDTH-1:0] op_result;
   logic                  last_rot;
   logic                  accept;

   // The rotation that brings the count to LATENCY is the final one.
   assign last_rot = (cnt_q == CNT_W'(LATENCY - 1));
   assign accept   = EN_I && START_I && (state_q != RUN);

`ifdef MC_RING_SATURATE_EN
   // Clamp a sign-extended (DATA_WIDTH+1)-bit sum/difference to the signed
   // range. Overflow shows up as the two top bits disagreeing; the extra top
   // bit then carries the true sign and picks the clamp direction.
   function automatic logic [DATA_WIDTH-1:0] sat_clamp(input logic [DATA_WIDTH:0] s);
      if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
         sat_clamp = s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
         sat_clamp = s[DATA_WIDTH-1:0];
      end
   endfunction

   logic [DATA_WIDTH:0] sum_ext;
   logic [DATA_WIDTH:0] diff_ext;
`endif

   // Result combiner. The result is captured on the final rotation edge, so it
   // works on the pre-rotation entries 1 and 2, which become entries 0 and 1
   // after that same edge.
   always_comb begin
      op_result = '0;
`ifdef MC_RING_SATURATE_EN
      sum_ext  = {ring_q[1][DATA_WIDTH-1], ring_q[1]} + {ring_q[2][DATA_WIDTH-1], ring_q[2]};
      diff_ext = {ring_q[1][DATA_WIDTH-1], ring_q[1]} - {ring_q[2][DATA_WIDTH-1], ring_q[2]};
`endif
      case (mode_q)
`ifdef MC_RING_SATURATE_EN
         2'b00: op_result = sat_clamp(sum_ext);
         2'b01: op_result = sat_clamp(diff_ext);
`else
         2'b00: op_result = ring_q[1] + ring_q[2];
         2'b01: op_result = ring_q[1] - ring_q[2];
`endif
         2'b10: op_result = ring_q[1] ^ ring_q[2];
         2'b11: op_result = ring_q[1];
      endcase
   end

   // State register. Reset aborts any operation in flight immediately.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q <= IDLE;
      end else if (EN_I) begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Starts that arrive during RUN are dropped, not queued;
   // a start seen in DONE immediately begins the next operation.
   always_comb begin
      state_d = state_q;
      if (EN_I) begin
         case (state_q)
            IDLE, DONE: if (START_I) state_d = RUN;
            RUN:        if (last_rot) state_d = DONE;
            default:    state_d = IDLE;
         endcase
      end
   end

   // Handshake outputs are decoded from the state register only, so BUSY_O
   // and VALID_O change only on a clock edge or on reset.
   always_comb begin
      READY_O = (state_q == IDLE) || (state_q == DONE);
      BUSY_O  = (state_q == RUN);
      VALID_O = (state_q == DONE);
   end

   // Datapath: ring load on accepted start, rotation and counting during RUN,
   // and result capture on the final rotation. Entries beyond index 2 load as
   // zero so the ring contents are fully defined for any DEPTH.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
         cnt_q    <= '0;
         mode_q   <= 2'b00;
         result_q <= '0;
      end else if (EN_I) begin
         if (accept) begin
            for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
            ring_q[1] <= OP_A_I;
            ring_q[2] <= OP_B_I;
            cnt_q     <= '0;
            mode_q    <= MODE_I;
         end else if (state_q == RUN) begin
            for (int i = 0; i < DEPTH - 1; i++) ring_q[i] <= ring_q[i+1];
            ring_q[DEPTH-1] <= ring_q[0];
            cnt_q <= cnt_q + 1'b1;
            if (last_rot) result_q <= op_result;
         end
      end
   end

   assign RESULT_O = result_q;

endmodule

// File: tb/tb_mc_ring_op.sv
// ---------------------------------------------------------------------------
// tb_mc_ring_op
// Directed self-checking bench for mc_ring_op. Uses an 8-bit, 4-entry ring
// with LATENCY=5, so after the rotations entry 0 holds operand A and entry 1
// holds operand B. Expected results come from a reference model and are
// queued when a start is issued, then popped when VALID_O appears.
// ---------------------------------------------------------------------------
module tb_mc_ring_op;

   localparam int W     = 8;
   localparam int DEPTH = 4;
   localparam int LAT   = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic         start;
   logic [1:0]   mode;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         ready;
   logic         busy;
   logic         valid;
   logic [W-1:0] result;

   int           checks   = 0;
   int           failures = 0;
   logic [W-1:0] exp_q [$];

   mc_ring_op #(
      .DATA_WIDTH (W),
      .DEPTH      (DEPTH),
      .LATENCY    (LAT)
   ) u_dut (
      .CLK_I    (clk),
      .RST_I    (rst),
      .EN_I     (en),
      .START_I  (start),
      .MODE_I   (mode),
      .OP_A_I   (op_a),
      .OP_B_I   (op_b),
      .READY_O  (ready),
      .BUSY_O   (busy),
      .VALID_O  (valid),
      .RESULT_O (result)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Reference model: builds the loaded ring, finds which entries sit at
   // positions 0 and 1 after LAT rotations, and evaluates the mode on them
   // using plain integer arithmetic.
   function automatic logic [W-1:0] modelResult(input logic [1:0] m,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
      logic [W-1:0] ring [DEPTH];
      logic [W-1:0] x;
      logic [W-1:0] y;
      int           s;
      for (int i = 0; i < DEPTH; i++) ring[i] = '0;
      ring[1] = a;
      ring[2] = b;
      x = ring[LAT % DEPTH];
      y = ring[(LAT + 1) % DEPTH];
      s = 0;
      case (m)
`ifdef MC_RING_SATURATE_EN
         2'b00: s = int'($signed(x)) + int'($signed(y));
         2'b01: s = int'($signed(x)) - int'($signed(y));
`else
         2'b00: s = int'(x) + int'(y);
         2'b01: s = int'(x) - int'(y);
`endif
         2'b10: s = int'(x ^ y);
         default: s = int'(x);
      endcase
`ifdef MC_RING_SATURATE_EN
      if (m == 2'b00 || m == 2'b01) begin
         if (s > 127)  s = 127;
         if (s < -128) s = -128;
      end
`endif
      return W'(s);
   endfunction

   // One comparison: counts it, and on mismatch counts and reports the failure.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Issue one start pulse on a single edge and queue its expected result.
   // Returns at the falling edge right after the accepting clock edge.
   task automatic applyStimulus(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start = 1'b1;
      mode  = m;
      op_a  = a;
      op_b  = b;
      exp_q.push_back(modelResult(m, a, b));
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) for VALID_O, counting cycles and BUSY_O cycles, optionally
   // pulling EN_I low for 4 cycles starting at cycle stallAt.
   task automatic waitResult(input string tag, input int stallAt, input int expCycles);
      int           k      = 0;
      int           busyN  = 0;
      logic [W-1:0] e;
      checkOutput({tag, " valid_drop"}, 32'(valid), 32'd0);
      checkOutput({tag, " ready_run"}, 32'(ready), 32'd0);
      while (valid !== 1'b1 && k < 200) begin
         if (busy === 1'b1) busyN++;
         if (stallAt >= 0 && k == stallAt) en = 1'b0;
         if (stallAt >= 0 && k == stallAt + 4) en = 1'b1;
         @(negedge clk);
         k++;
      end
      checkOutput({tag, " latency"}, 32'(k), 32'(expCycles));
      checkOutput({tag, " busy_cycles"}, 32'(busyN), 32'(expCycles));
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checkOutput({tag, " result"}, 32'(result), 32'(e));
      checkOutput({tag, " ready_done"}, 32'(ready), 32'd1);
      checkOutput({tag, " busy_done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int           pulses;
      int           doubles;
      logic         prevValid;
      logic [W-1:0] e;

      rst   = 1'b1;
      en    = 1'b1;
      start = 1'b0;
      mode  = 2'b00;
      op_a  = '0;
      op_b  = '0;

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst ready", 32'(ready), 32'd1);
      checkOutput("rst busy", 32'(busy), 32'd0);
      checkOutput("rst valid", 32'(valid), 32'd0);
      checkOutput("rst result", 32'(result), 32'd0);
      rst = 1'b0;

      // Basic add, then the result must hold while idling in DONE.
      applyStimulus(2'b00, 8'd5, 8'd7);
      waitResult("add", -1, LAT);
      repeat (3) @(negedge clk);
      checkOutput("hold valid", 32'(valid), 32'd1);
      checkOutput("hold result", 32'(result), 32'd12);

      // Each mode, plus wrap/saturation boundaries.
      applyStimulus(2'b01, 8'd5, 8'd7);
      waitResult("sub", -1, LAT);
      applyStimulus(2'b10, 8'hA5, 8'h3C);
      waitResult("xor", -1, LAT);
      applyStimulus(2'b11, 8'h42, 8'h11);
      waitResult("pass", -1, LAT);
      applyStimulus(2'b00, 8'h7F, 8'h01);
      waitResult("add_posovf", -1, LAT);
      applyStimulus(2'b01, 8'h00, 8'h01);
      waitResult("sub_zero_minus_one", -1, LAT);
      applyStimulus(2'b01, 8'h80, 8'h01);
      waitResult("sub_negovf", -1, LAT);
      applyStimulus(2'b00, 8'h80, 8'hFF);
      waitResult("add_negovf", -1, LAT);

      // Enable stall mid-RUN: result 4 cycles late, value unchanged.
      applyStimulus(2'b00, 8'h10, 8'h20);
      waitResult("stall", 2, LAT + 4);

      // Start while disabled is ignored.
      @(negedge clk);
      en    = 1'b0;
      start = 1'b1;
      mode  = 2'b10;
      @(negedge clk);
      checkOutput("en_low valid", 32'(valid), 32'd1);
      checkOutput("en_low busy", 32'(busy), 32'd0);
      checkOutput("en_low result", 32'(result), 32'h30);
      en    = 1'b1;
      start = 1'b0;

      // START held high: one op per LAT+1 cycles, one-cycle VALID pulses.
      @(negedge clk);
      start = 1'b1;
      mode  = 2'b10;
      op_a  = 8'h0F;
      op_b  = 8'hF0;
      for (int n = 0; n < 3; n++) exp_q.push_back(modelResult(2'b10, 8'h0F, 8'hF0));
      pulses    = 0;
      doubles   = 0;
      prevValid = 1'b0;
      for (int i = 0; i < 3 * (LAT + 1); i++) begin
         @(negedge clk);
         if (valid === 1'b1) begin
            if (prevValid) doubles++;
            checkOutput("held pulse_pos", 32'(i), 32'(LAT + pulses * (LAT + 1)));
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checkOutput("held result", 32'(result), 32'(e));
            pulses++;
         end
         prevValid = valid;
      end
      start = 1'b0;
      checkOutput("held pulses", 32'(pulses), 32'd3);
      checkOutput("held double_valid", 32'(doubles), 32'd0);

      // Asynchronous reset mid-RUN aborts with no clock edge needed.
      applyStimulus(2'b00, 8'd1, 8'd2);
      @(negedge clk);
      checkOutput("abort busy_before", 32'(busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort valid", 32'(valid), 32'd0);
      checkOutput("abort result", 32'(result), 32'd0);
      checkOutput("abort ready", 32'(ready), 32'd1);
      exp_q.delete();
      #1;
      rst = 1'b0;

      // Normal operation after the abort.
      applyStimulus(2'b00, 8'd3, 8'd4);
      waitResult("post_rst", -1, LAT);
      checkOutput("scoreboard empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc_ring_op.md
Name: mc_ring_op

Overview:
Parametrised multi-cycle operator for the datapath's operator pool. It loads two operands into a DEPTH-entry rotating register ring and rotates the ring for LATENCY cycles. It then combines ring entries 0 and 1 under a runtime-selected mode. A start/busy/valid handshake lets the scheduler issue back-to-back operations without guessing latency.

Parameters:
DATA_WIDTH, 32, operand, ring-entry and result width in bits
DEPTH, 3, number of ring registers; legal range >= 3
LATENCY, 3, number of rotations before the result is produced; legal range >= 1

Ports:
CLK_I  input  1  clock, all state updates on rising edge
RST_I  input  1  reset, asynchronous, active-high
EN_I  input  1  global enable; low freezes every register
START_I  input  1  request a new operation; sampled only when READY_O=1 and EN_I=1
MODE_I  input  2  operation select, latched on start: 00 add, 01 sub (r0-r1), 10 xor, 11 pass r0
OP_A_I  input  DATA_WIDTH  operand A
OP_B_I  input  DATA_WIDTH  operand B
READY_O  output  1  combinational; 1 in IDLE or DONE
BUSY_O  output  1  registered; 1 in RUN
VALID_O  output  1  registered; 1 in DONE
RESULT_O  output  DATA_WIDTH  registered result; holds its value until the next result is written

Behaviour:
- Reset: asynchronous, active-high. Forces state IDLE, all ring entries r[0..DEPTH-1]=0, rotation counter=0 and latched mode=00. Outputs: RESULT_O=0, BUSY_O=0, VALID_O=0, READY_O=1. Asserting reset during RUN aborts the operation immediately; no result is produced.
- EN_I=0: state, ring, counter, mode and outputs all hold. START_I is ignored.
- FSM states: IDLE, RUN, DONE. All transitions below require EN_I=1.
  - IDLE or DONE with START_I=1 -> RUN.
    - Load the ring: r[0]=0, r[1]=OP_A_I, r[2]=OP_B_I, r[k]=0 for k>=3.
    - Counter=0; latch MODE_I; VALID_O drops to 0.
  - IDLE or DONE with START_I=0 -> stay. In DONE, VALID_O and RESULT_O hold.
  - RUN: each cycle rotates the ring: r[i] <= r[i+1] for i<DEPTH-1, and r[DEPTH-1] <= r[0]. Counter increments.
  - RUN, on the cycle performing rotation number LATENCY (counter==LATENCY-1) -> DONE.
    - RESULT_O <= f(post-rotation r[0], r[1]), computed from the pre-rotation r[1], r[2].
    - VALID_O=1 from the next cycle.
  - RUN with START_I=1: the request is ignored, not queued. The scheduler must watch READY_O.
- Latency: START_I sampled at edge t; VALID_O and RESULT_O are valid after edge t+LATENCY. Back-to-back issue from DONE is allowed: the start accepted in DONE drops VALID_O on the same edge.
- Arithmetic: add and sub wrap modulo 2^DATA_WIDTH. No carry or overflow outputs.
- Counter width: clog2(LATENCY+1). The counter never wraps during a legal operation.

Optional Feature:
MC_RING_SATURATE_EN
- Defined: add and sub treat r[0], r[1] as signed two's complement and clamp to the signed range. Positive overflow gives 2^(DATA_WIDTH-1)-1; negative overflow gives -2^(DATA_WIDTH-1). xor and pass are unchanged.
- Undefined: add and sub wrap as in the Behaviour section.
- Latency and handshake are identical in both builds.

Test Plan:
- DEPTH=3, LATENCY=1, add, A=5, B=7, start at edge 0 -> VALID_O=1 after edge 1, RESULT_O=12.
- DEPTH=3, LATENCY=3, add, A=5, B=7 -> ring returns to [0,5,7]; RESULT_O=5 after edge 3; BUSY_O=1 for exactly 3 cycles.
- LATENCY=2, sub, A=5, B=7 -> RESULT_O=7. Then, with 8-bit width, swap the ring to r0=0, r1=1: sub gives 0xFF when wrapping; with MC_RING_SATURATE_EN, add of 0x7F+0x01 gives 0x7F.
- EN_I low for 4 cycles mid-RUN -> BUSY_O stays 1 and the ring is frozen; the result arrives 4 cycles late and is unchanged in value.
- START_I held high across RUN and DONE, LATENCY=3 -> the new operation starts exactly at the DONE cycle; RUN-phase starts are ignored; VALID_O pulses 1 cycle per operation.
- RST_I asserted asynchronously mid-RUN -> BUSY_O, VALID_O and RESULT_O go to 0 without waiting for a clock edge; READY_O=1.
